// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and bus constants for the I2C target model
//
// Purpose: state encoding for the target FSM plus the I2C bit-level constants
// used when driving and sampling ACK/NACK and the R/W bit.
// Ports: none (package).
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } i2c_tgt_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, optional majority filter and edge strobes for one I2C line
//
// Purpose: brings an asynchronous bus line into the clk_i domain and produces
// a clean level plus one-cycle rise/fall strobes aligned with that level.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample majority vote).
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous active-high reset
//   line_i  in   raw asynchronous line
//   level_o out  filtered level, already showing the new value when a strobe fires
//   rise_o  out  one-cycle pulse on a 0->1 transition
//   fall_o  out  one-cycle pulse on a 1->0 transition
module i2c_line_filter (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic filt;
  logic level_q;
  logic rise_q;
  logic fall_q;

  // Idle bus is pulled high, so the synchronizer resets to 1 to avoid a
  // false falling edge right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], sync2_q};
    end
  end

  // A single-cycle pulse occupies only one history slot and is outvoted.
  assign filt = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign filt = sync2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= filt;
      rise_q  <= filt & ~level_q;
      fall_q  <= ~filt & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_model.sv
// rtl/i2c_target_model.sv - I2C target with a pointer-addressed byte register file
//
// Purpose: responds at DEV_ADDR, accepts a pointer byte followed by
// auto-incrementing writes, and serves auto-incrementing reads (repeated
// START supported). Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN
// (applied inside i2c_line_filter).
// Ports:
//   clk_i       in   system clock
//   rst_i       in   synchronous active-high reset
//   scl_i       in   asynchronous SCL
//   sda_i       in   asynchronous resolved SDA
//   sda_oe_o    out  1 = pull SDA low
//   wr_valid_o  out  one-cycle pulse per byte written
//   wr_addr_o   out  register index of that write
//   wr_data_o   out  byte written
//   busy_o      out  addressed and between START and STOP
module i2c_target_model
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int          NUM_REGS = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe_o,
  output logic                        wr_valid_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
  output logic [7:0]                  wr_data_o,
  output logic                        busy_o
);

  localparam int AW = $clog2(NUM_REGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter u_scl_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .line_i  (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter u_sda_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .line_i  (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic start_det;
  logic stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_tgt_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           rw_q, rw_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic           wr_valid_q, wr_valid_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [7:0]     regs_q [NUM_REGS];

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic [2:0] bit_idx;

  assign rx_byte = {shift_q[6:0], sda_lvl};
  assign rd_byte = regs_q[ptr_q];
  assign bit_idx = 3'd7 - cnt_q[2:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (wr_valid_d) begin
        regs_q[ptr_q] <= rx_byte;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
                state_d = ST_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end
            end
          end
        end

        // ACK states see two SCL falls: the first starts the ACK drive,
        // the second ends it and hands SDA to the next phase.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              shift_d  = rd_byte;
              ptr_d    = ptr_q + AW'(1);
              cnt_d    = 4'd0;
              sda_oe_d = ~rd_byte[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = ST_PTR;
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              ptr_d   = rx_byte[AW-1:0];
              state_d = ST_PTR_ACK;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = ST_WDATA;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d      = 4'd0;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
              ptr_d      = ptr_q + AW'(1);
              state_d    = ST_WDATA_ACK;
            end
          end
        end

        // cnt counts SCL rises already seen in this byte; after the 8th the
        // next fall releases SDA for the master's ACK/NACK.
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RACK;
            end else begin
              sda_oe_d = ~shift_q[bit_idx];
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              shift_d = rd_byte;
              ptr_d   = ptr_q + AW'(1);
              cnt_d   = 4'd0;
              state_d = ST_RDATA;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target_model.sv
// tb/tb_i2c_target_model.sv - directed scoreboard bench for i2c_target_model
module tb_i2c_target_model;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda_line = sda_m & ~sda_oe;

  int         compared = 0;
  int         mismatched = 0;
  logic [11:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic        oe_seen = 1'b0;
  int          glitch_idx = -1;
  logic        glitch_now = 1'b0;

  i2c_target_model #(.DEV_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port scoreboard: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (!rst && wr_valid) begin
      compared++;
      assert (wr_exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL wr_unexpected: observed 0x%0h expected none", {wr_addr, wr_data});
      end
      if (wr_exp_q.size() != 0) begin
        logic [11:0] e;
        e = wr_exp_q.pop_front();
        chk("wr_port", {20'd0, wr_addr, wr_data}, {20'd0, e});
        compared--;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: SDA set mid-low, sampled mid-high.
  task automatic bus_bit(input logic b, output logic r);
    wait_clk(8);
    sda_m = b;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(4);
    if (glitch_now) begin
      scl = 1'b0;
      wait_clk(1);
      scl = 1'b1;
      glitch_now = 1'b0;
    end
    wait_clk(4);
    r = sda_line;
    wait_clk(8);
    scl = 1'b0;
  endtask

  task automatic do_start;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    sda_m = 1'b0;
    wait_clk(8);
    scl = 1'b0;
  endtask

  task automatic do_stop;
    wait_clk(8);
    sda_m = 1'b0;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic wb(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      glitch_now = (i == glitch_idx);
      bus_bit(d[i], r);
    end
    glitch_idx = -1;
    bus_bit(1'b1, ack);
  endtask

  task automatic rb(input logic m_ack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      d = {d[6:0], r};
    end
    bus_bit(m_ack, r);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       r;

    wait_clk(4);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(4);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_wr_out", {20'd0, wr_addr, wr_data}, 32'd0);

    // Write 0xA5, 0x5A starting at pointer 3.
    wr_exp_q.push_back({4'd3, 8'hA5});
    wr_exp_q.push_back({4'd4, 8'h5A});
    do_start;
    wb(8'hA0, ack); chk("w_addr_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    chk("w_busy", {31'd0, busy}, 32'd1);
    wb(8'h03, ack); chk("w_ptr_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    wb(8'hA5, ack); chk("w_d0_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    wb(8'h5A, ack); chk("w_d1_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    do_stop;
    chk("w_busy_stop", {31'd0, busy}, 32'd0);
    chk("w_drain", wr_exp_q.size(), 32'd0);

    // Read back through a repeated START.
    rd_exp_q.push_back(8'hA5);
    rd_exp_q.push_back(8'h5A);
    do_start;
    wb(8'hA0, ack);
    wb(8'h03, ack); chk("r_ptr_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    do_start;
    wb(8'hA1, ack); chk("r_addr_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    rb(I2C_ACK, d);  chk("r_byte0", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    rb(I2C_NACK, d); chk("r_byte1", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    chk("r_idle_after_nack", 32'(dut.state_q), 32'(ST_IDLE));
    chk("r_released", {31'd0, sda_oe}, 32'd0);
    do_stop;

    // Wrong address: never acknowledged, never driven, nothing written.
    oe_seen = 1'b0;
    do_start;
    wb(8'hA2, ack); chk("x_addr_nack", {31'd0, ack}, {31'd0, I2C_NACK});
    wb(8'h33, ack); chk("x_data_nack", {31'd0, ack}, {31'd0, I2C_NACK});
    do_stop;
    chk("x_oe_never", {31'd0, oe_seen}, 32'd0);

    // Pointer wrap 15 -> 0.
    wr_exp_q.push_back({4'd15, 8'h11});
    wr_exp_q.push_back({4'd0, 8'h22});
    do_start;
    wb(8'hA0, ack);
    wb(8'h0F, ack);
    wb(8'h11, ack);
    wb(8'h22, ack); chk("wrap_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    do_stop;
    chk("wrap_drain", wr_exp_q.size(), 32'd0);
    rd_exp_q.push_back(8'h11);
    rd_exp_q.push_back(8'h22);
    do_start;
    wb(8'hA0, ack);
    wb(8'h0F, ack);
    do_start;
    wb(8'hA1, ack);
    rb(I2C_ACK, d);  chk("wrap_rd0", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    rb(I2C_NACK, d); chk("wrap_rd1", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    do_stop;

    // Reset in the middle of a read byte while bit 6 (0) of 0xA5 is driven.
    do_start;
    wb(8'hA0, ack);
    wb(8'h03, ack);
    do_start;
    wb(8'hA1, ack);
    bus_bit(1'b1, r); chk("rr_bit7", {31'd0, r}, 32'd1);
    wait_clk(8);
    chk("rr_oe_pre_rst", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    wait_clk(1);
    chk("rr_oe_post_rst", {31'd0, sda_oe}, 32'd0);
    rst = 1'b0;
    do_stop;
    wr_exp_q.push_back({4'd2, 8'h77});
    do_start;
    wb(8'hA0, ack); chk("rr_addr_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    wb(8'h02, ack);
    wb(8'h77, ack);
    do_stop;
    chk("rr_drain", wr_exp_q.size(), 32'd0);
    rd_exp_q.push_back(8'h77);
    rd_exp_q.push_back(8'h00);
    do_start;
    wb(8'hA0, ack);
    wb(8'h02, ack);
    do_start;
    wb(8'hA1, ack);
    rb(I2C_ACK, d);  chk("rr_rd0", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    rb(I2C_NACK, d); chk("rr_rd1_cleared", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    do_stop;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // One-cycle low glitch on SCL during a data bit must be ignored.
    wr_exp_q.push_back({4'd6, 8'hC3});
    do_start;
    wb(8'hA0, ack);
    wb(8'h06, ack);
    glitch_idx = 3;
    wb(8'hC3, ack); chk("g_ack", {31'd0, ack}, {31'd0, I2C_ACK});
    do_stop;
    chk("g_drain", wr_exp_q.size(), 32'd0);
`endif

    wait_clk(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
